frame_streamer: RTL and testbench
=================================

FRAME_STREAMER -- requirements
Module: frame_streamer

Interface
REQ-001 Parameter DATA_W, default 16, word width (signed fixed point, passed through unmodified) SHALL be provided.
REQ-002 Parameter FRAME_LEN, default 137, words per frame SHALL be provided.
REQ-003 Parameter ADDR_W, default 8, index width; FRAME_LEN <= 2**ADDR_W SHALL hold.
REQ-004 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 wr_en  input  1  frame-memory write strobe.
REQ-007 wr_addr  input  ADDR_W  write index.
REQ-008 wr_data  input  DATA_W  write word.
REQ-009 start  input  1  begin streaming the stored frame.
REQ-010 hold  input  1  stall streaming.
REQ-011 data_out  output  DATA_W  streamed word (registered).
REQ-012 valid  output  1  data_out carries a frame word this cycle.
REQ-013 last  output  1  final word of frame (FRAME_LEN-1) on data_out.
REQ-014 busy  output  1  streaming in progress.
REQ-015 done  output  1  one-cycle end-of-frame pulse.
REQ-016 wr_err  output  1  one-cycle pulse, rejected write.

Function
REQ-017 Block SHALL be the producer for the frame accumulator: emits FRAME_LEN words, one per non-held cycle, so the downstream sum covers the whole frame.
REQ-018 Storage: FRAME_LEN x DATA_W register array, not cleared by reset.
REQ-019 FSM SHALL have two states: IDLE, STREAM; busy = (state == STREAM), registered.
REQ-020 Write accepted only when state IDLE, wr_en=1, wr_addr < FRAME_LEN: mem[wr_addr] <= wr_data at that edge.
REQ-021 wr_en=1 with state STREAM or wr_addr >= FRAME_LEN: write dropped, wr_err=1 next cycle only.
REQ-022 IDLE, start=1 at edge k: state->STREAM, data_out<=mem[0], valid<=1, idx<=1; last<=1 only if FRAME_LEN==1.
REQ-023 Write and start at same IDLE edge: write SHALL complete; streamed word 0 SHALL be the old mem[0] when wr_addr==0 (read-before-write).
REQ-024 STREAM, hold=0, idx < FRAME_LEN: data_out<=mem[idx], valid<=1, last<=(idx==FRAME_LEN-1), idx<=idx+1.
REQ-025 STREAM, hold=0, idx == FRAME_LEN: valid<=0, last<=0, done<=1, state->IDLE, idx<=0; done cleared the following cycle.
REQ-026 STREAM, hold=1: valid<=0, last<=0, idx and data_out unchanged; next hold=0 edge resumes at same idx (no word lost or repeated).
REQ-027 Latency: first valid word at cycle k+1 after start edge k; with hold=0 throughout, valid high FRAME_LEN consecutive cycles, done high at cycle k+FRAME_LEN+1.
REQ-028 start during STREAM SHALL be ignored (no restart, no error); start in the done cycle (state IDLE) SHALL launch a new frame.
REQ-029 IDLE: valid=0, last=0, data_out holds last streamed value.
REQ-030 idx SHALL never exceed FRAME_LEN; no wrap-around inside a frame.

Reset
REQ-031 rst_n=0 SHALL immediately (asynchronously) force state=IDLE, idx=0, data_out=0, valid=0, last=0, busy=0, done=0, wr_err=0.
REQ-032 Reset mid-STREAM SHALL abort the frame with no done pulse; memory contents retained.
REQ-033 After rst_n deasserts, first start SHALL stream from word 0.

Verification
REQ-034 Write mem[i]=i+1 for i=0..136, start, hold=0 -> 137 valid beats 1..137, last only on value 137, done one cycle after, busy low with done.
REQ-035 Same frame, hold=1 for 3 cycles after beat 10 -> valid low 3 cycles, beat 11 value 12 follows, done delayed by 3 cycles.
REQ-036 Write wr_addr=137 in IDLE, and wr_addr=5 during STREAM -> each wr_err one-cycle pulse, mem unchanged, streamed values unchanged.
REQ-037 start pulsed at beat 50 -> ignored, frame finishes normally; start in done cycle -> new frame's word 0 appears next cycle.
REQ-038 rst_n low at beat 70 -> all outputs 0 asynchronously, no done; restart after release streams values 1..137 again.
REQ-039 Downstream accumulator fed by data_out gated with valid, mem all 16'h0001 -> accumulator sum 137 (16'h0089).

Source files
------------

// File: rtl/frame_streamer.sv
// frame_streamer
//   Holds one frame of FRAME_LEN signed words in a register array and streams
//   it out, one word per non-held cycle, to a downstream frame accumulator.
//
//   Ports
//     clk      in   single clock, rising edge
//     rst_n    in   asynchronous active-low reset (memory is not cleared)
//     wr_en    in   frame-memory write strobe (accepted only while idle)
//     wr_addr  in   ADDR_W write index
//     wr_data  in   DATA_W write word
//     start    in   begin streaming the stored frame (ignored while streaming)
//     hold     in   stall streaming; no word is lost or repeated
//     data_out out  DATA_W streamed word, registered; holds value when idle
//     valid    out  data_out carries a frame word this cycle
//     last     out  data_out is word FRAME_LEN-1
//     busy     out  streaming in progress
//     done     out  one-cycle end-of-frame pulse
//     wr_err   out  one-cycle pulse for a rejected write
module frame_streamer #(
  parameter int DATA_W    = 16,
  parameter int FRAME_LEN = 137,
  parameter int ADDR_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              start,
  input  logic              hold,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  output logic              last,
  output logic              busy,
  output logic              done,
  output logic              wr_err
);

  // idx must be able to hold FRAME_LEN itself (end-of-frame marker), which
  // needs one bit more than a plain word index when FRAME_LEN == 2**ADDR_W.
  localparam int IDX_W = ADDR_W + 1;
  localparam logic [IDX_W-1:0] LEN      = IDX_W'(FRAME_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                done_q, done_d;
  logic                wr_err_q, wr_err_d;

  logic [DATA_W-1:0]   mem_q [FRAME_LEN];
  logic                wr_ok;
  logic [ADDR_W-1:0]   rd_addr;

  assign wr_ok   = wr_en && (state_q == IDLE) && ({1'b0, wr_addr} < LEN);
  // Only used while idx_q < FRAME_LEN, so the dropped top bit is always zero.
  assign rd_addr = idx_q[ADDR_W-1:0];

  // State register plus registered datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
      wr_err_q <= wr_err_d;
    end
  end

  // Frame memory has no reset so a frame survives an aborted stream.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = STREAM;
      STREAM:  if (!hold && (idx_q == LEN)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output / datapath logic. Reads use mem_q before the edge, so a write to
  // word 0 on the start edge streams the old word 0.
  always_comb begin
    idx_d    = idx_q;
    data_d   = data_q;
    valid_d  = 1'b0;
    last_d   = 1'b0;
    done_d   = 1'b0;
    wr_err_d = wr_en && !wr_ok;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        if (start) begin
          data_d  = mem_q[0];
          valid_d = 1'b1;
          last_d  = (FRAME_LEN == 1);
          idx_d   = IDX_W'(1);
        end
      end
      STREAM: begin
        if (!hold) begin
          if (idx_q == LEN) begin
            done_d = 1'b1;
            idx_d  = '0;
          end else begin
            data_d  = mem_q[rd_addr];
            valid_d = 1'b1;
            last_d  = (idx_q == LAST_IDX);
            idx_d   = idx_q + IDX_W'(1);
          end
        end
      end
      default: idx_d = '0;
    endcase
  end

  assign data_out = data_q;
  assign valid    = valid_q;
  assign last     = last_q;
  assign busy     = (state_q == STREAM);
  assign done     = done_q;
  assign wr_err   = wr_err_q;

endmodule

// File: tb/tb_frame_streamer.sv
// Directed bench for frame_streamer with default parameters.
module tb_frame_streamer;
  localparam int DW = 16;
  localparam int FL = 137;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          start = 1'b0;
  logic          hold = 1'b0;
  logic [DW-1:0] data_out;
  logic          valid, last, busy, done, wr_err;

  int n_vec = 0;
  int n_err = 0;

  frame_streamer #(.DATA_W(DW), .FRAME_LEN(FL), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .start(start), .hold(hold), .data_out(data_out),
    .valid(valid), .last(last), .busy(busy), .done(done), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Bounded wait for done; callers judge the returned flag.
  task automatic run_to_done(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic load_ramp;
    for (int i = 0; i < FL; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = DW'(i + 1);
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #3;
    n_vec++;
    if (data_out !== '0) begin
      n_err++; $display("FAIL reset_data got=%h exp=0000", data_out);
    end
    n_vec++;
    if ({valid, last, busy, done, wr_err} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags got=%b exp=00000", {valid, last, busy, done, wr_err});
    end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_full_frame;
    pulse_start();
    for (int b = 0; b < FL; b++) begin
      n_vec++;
      if (valid !== 1'b1 || data_out !== DW'(b + 1)) begin
        n_err++; $display("FAIL full_beat%0d got v=%b d=%h exp v=1 d=%h", b, valid, data_out, DW'(b + 1));
      end
      n_vec++;
      if (last !== (b == FL - 1) || done !== 1'b0 || busy !== 1'b1) begin
        n_err++; $display("FAIL full_flags%0d got l=%b dn=%b bz=%b exp l=%b dn=0 bz=1", b, last, done, busy, b == FL - 1);
      end
      tick();
    end
    n_vec++;
    if ({done, valid, last, busy} !== 4'b1000) begin
      n_err++; $display("FAIL full_done got d/v/l/b=%b exp 1000", {done, valid, last, busy});
    end
    tick();
    n_vec++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL full_done_pulse got=%b exp=0", done);
    end
  endtask

  task automatic test_hold;
    pulse_start();
    for (int b = 0; b <= 10; b++) begin
      n_vec++;
      if (valid !== 1'b1 || data_out !== DW'(b + 1)) begin
        n_err++; $display("FAIL hold_pre%0d got v=%b d=%h exp v=1 d=%h", b, valid, data_out, DW'(b + 1));
      end
      if (b < 10) tick();
    end
    hold = 1'b1;
    for (int h = 0; h < 3; h++) begin
      tick();
      n_vec++;
      if (valid !== 1'b0 || data_out !== 16'd11 || busy !== 1'b1 || last !== 1'b0) begin
        n_err++; $display("FAIL hold_stall%0d got v=%b d=%h bz=%b exp v=0 d=000b bz=1", h, valid, data_out, busy);
      end
    end
    hold = 1'b0;
    for (int b = 11; b < FL; b++) begin
      tick();
      n_vec++;
      if (valid !== 1'b1 || data_out !== DW'(b + 1) || done !== 1'b0) begin
        n_err++; $display("FAIL hold_post%0d got v=%b d=%h dn=%b exp v=1 d=%h dn=0", b, valid, data_out, done, DW'(b + 1));
      end
    end
    tick();
    n_vec++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      n_err++; $display("FAIL hold_done got dn=%b v=%b exp dn=1 v=0", done, valid);
    end
    tick();
  endtask

  task automatic test_wr_err;
    wr_en = 1'b1; wr_addr = 8'd137; wr_data = 16'hDEAD;
    tick();
    wr_en = 1'b0;
    n_vec++;
    if (wr_err !== 1'b1) begin
      n_err++; $display("FAIL wrerr_range got=%b exp=1", wr_err);
    end
    tick();
    n_vec++;
    if (wr_err !== 1'b0) begin
      n_err++; $display("FAIL wrerr_range_pulse got=%b exp=0", wr_err);
    end
    pulse_start();
    for (int b = 0; b < FL; b++) begin
      n_vec++;
      if (valid !== 1'b1 || data_out !== DW'(b + 1)) begin
        n_err++; $display("FAIL wrerr_beat%0d got v=%b d=%h exp v=1 d=%h", b, valid, data_out, DW'(b + 1));
      end
      if (b == 2) begin
        wr_en = 1'b1; wr_addr = 8'd5; wr_data = 16'hBEEF;
      end
      if (b == 3) begin
        wr_en = 1'b0;
        n_vec++;
        if (wr_err !== 1'b1) begin
          n_err++; $display("FAIL wrerr_stream got=%b exp=1", wr_err);
        end
      end
      if (b == 4) begin
        n_vec++;
        if (wr_err !== 1'b0) begin
          n_err++; $display("FAIL wrerr_stream_pulse got=%b exp=0", wr_err);
        end
      end
      tick();
    end
    n_vec++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL wrerr_done got=%b exp=1", done);
    end
    tick();
  endtask

  // Ends with a fresh frame already streaming and word 0 on data_out.
  task automatic test_back_to_back;
    pulse_start();
    for (int b = 0; b < FL; b++) begin
      n_vec++;
      if (valid !== 1'b1 || data_out !== DW'(b + 1) || busy !== 1'b1) begin
        n_err++; $display("FAIL b2b_beat%0d got v=%b d=%h bz=%b exp v=1 d=%h bz=1", b, valid, data_out, busy, DW'(b + 1));
      end
      if (b == 50) start = 1'b1;
      if (b == 51) start = 1'b0;
      tick();
    end
    n_vec++;
    if (done !== 1'b1 || valid !== 1'b0) begin
      n_err++; $display("FAIL b2b_done got dn=%b v=%b exp dn=1 v=0", done, valid);
    end
    pulse_start();
    n_vec++;
    if ({valid, busy, done} !== 3'b110 || data_out !== 16'd1) begin
      n_err++; $display("FAIL b2b_restart got v/bz/dn=%b d=%h exp 110 d=0001", {valid, busy, done}, data_out);
    end
  endtask

  task automatic test_reset_mid;
    for (int b = 0; b <= 70; b++) begin
      n_vec++;
      if (valid !== 1'b1 || data_out !== DW'(b + 1)) begin
        n_err++; $display("FAIL rmid_beat%0d got v=%b d=%h exp v=1 d=%h", b, valid, data_out, DW'(b + 1));
      end
      if (b < 70) tick();
    end
    rst_n = 1'b0;
    #2;
    n_vec++;
    if (data_out !== '0 || {valid, last, busy, done, wr_err} !== 5'b0) begin
      n_err++; $display("FAIL rmid_async got d=%h flags=%b exp d=0000 flags=00000", data_out, {valid, last, busy, done, wr_err});
    end
    tick(); tick();
    n_vec++;
    if (done !== 1'b0 || valid !== 1'b0) begin
      n_err++; $display("FAIL rmid_nodone got dn=%b v=%b exp 0 0", done, valid);
    end
    rst_n = 1'b1;
    tick();
    n_vec++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL rmid_release got dn=%b bz=%b exp 0 0", done, busy);
    end
    test_full_frame();
  endtask

  task automatic test_read_before_write;
    bit ok;
    wr_en = 1'b1; wr_addr = 8'd0; wr_data = 16'h0055; start = 1'b1;
    tick();
    wr_en = 1'b0; start = 1'b0;
    n_vec++;
    if (data_out !== 16'h0001 || valid !== 1'b1 || wr_err !== 1'b0) begin
      n_err++; $display("FAIL rbw_old got d=%h v=%b we=%b exp d=0001 v=1 we=0", data_out, valid, wr_err);
    end
    run_to_done(ok);
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL rbw_timeout1 got done=0 exp done=1");
    end
    tick();
    pulse_start();
    n_vec++;
    if (data_out !== 16'h0055) begin
      n_err++; $display("FAIL rbw_new got=%h exp=0055", data_out);
    end
    run_to_done(ok);
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL rbw_timeout2 got done=0 exp done=1");
    end
    tick();
  endtask

  task automatic test_accum;
    logic [15:0] sum;
    int c;
    for (int i = 0; i < FL; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = 16'h0001;
      tick();
    end
    wr_en = 1'b0;
    sum = '0;
    pulse_start();
    for (c = 0; c < 300 && !done; c++) begin
      if (valid) sum = sum + data_out;
      tick();
    end
    n_vec++;
    if (done !== 1'b1) begin
      n_err++; $display("FAIL accum_timeout got done=%b exp=1", done);
    end
    n_vec++;
    if (sum !== 16'h0089) begin
      n_err++; $display("FAIL accum_sum got=%h exp=0089", sum);
    end
    tick();
  endtask

  initial begin
    test_reset();
    load_ramp();
    test_full_frame();
    test_hold();
    test_wr_err();
    test_back_to_back();
    test_reset_mid();
    test_read_before_write();
    test_accum();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
